// File: rtl/match_run_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : match_run_detector_pkg
//  Brief    : State encodings shared by the match run detector.
//  Revision : 1.0  initial release
// ============================================================================
package match_run_detector_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_NOKEY  = 2'd0,
    S_SEARCH = 2'd1,
    S_RUN    = 2'd2,
    S_HIT    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/match_run_detector_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at all-ones; clr wins over inc.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] q_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign q_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/match_run_detector.sv
`default_nettype none
// ============================================================================
//  Module   : match_run_detector
//  Brief    : Counts consecutive key matches on an accepted sample stream and
//             pulses hit when a run of RUN_LEN completes. Define
//             MATCH_OVERLAP_EN for sliding-window (overlapping) runs.
//  Revision : 1.0  initial release
// ============================================================================
module match_run_detector #(
  parameter int WIDTH   = 4,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             key_load_i,
  input  logic [WIDTH-1:0] key_in_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             hit_o,
  output logic [CNT_W-1:0] run_cnt_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic             key_valid_o
);

  import match_run_detector_pkg::*;

  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
`ifdef MATCH_OVERLAP_EN
  localparam logic [CNT_W-1:0] HIT_CNT_C = RUN_LEN_C;
`else
  localparam logic [CNT_W-1:0] HIT_CNT_C = '0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] run_inc;
  logic             accept;
  logic             match;

  assign in_ready_o = (state_q != S_NOKEY) && !key_load_i;
  assign accept     = in_valid_i && in_ready_o;
  assign match      = (in_data_i == key_q);
  // Clamp keeps an overlapping run parked at RUN_LEN while matches continue.
  assign run_inc    = (run_cnt_q >= RUN_LEN_C) ? RUN_LEN_C : run_cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_NOKEY;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    run_cnt_d   = run_cnt_q;
    if (key_load_i) begin
      key_d       = key_in_i;
      key_valid_d = 1'b1;
      run_cnt_d   = '0;
      state_d     = S_SEARCH;
    end else if (state_q != S_NOKEY) begin
      if (accept) begin
        if (!match) begin
          run_cnt_d = '0;
          state_d   = S_SEARCH;
        end else if (run_inc == RUN_LEN_C) begin
          run_cnt_d = HIT_CNT_C;
          state_d   = S_HIT;
        end else begin
          run_cnt_d = run_inc;
          state_d   = S_RUN;
        end
      end else if (state_q == S_HIT) begin
        run_cnt_d = '0;
        state_d   = S_SEARCH;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_count (
    .clk_i (clk_i),
    .clr_i (reset_i),
    .inc_i (state_d == S_HIT),
    .q_o   (hit_count_o)
  );

  assign hit_o       = (state_q == S_HIT);
  assign run_cnt_o   = run_cnt_q;
  assign key_valid_o = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_match_run_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_run_detector
//  Brief    : Vector table + scoreboard bench for match_run_detector; a second
//             instance covers RUN_LEN=1 with a 2-bit saturating tally.
//  Revision : 1.0  initial release
// ============================================================================
module tb_match_run_detector;

  typedef struct {
    logic       rst;
    logic       kl;
    logic [3:0] kin;
    logic       v;
    logic [3:0] d;
    logic       rdy;
    logic       hit;
    logic [7:0] rc;
    logic [7:0] hc;
    logic       kv;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [7:0] rc;
    logic [7:0] hc;
    logic       kv;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, key_load, in_valid, in_ready, hit, key_valid;
  logic [3:0] key_in, in_data;
  logic [7:0] run_cnt, hit_count;

  logic       key_load2, in_valid2, in_ready2, hit2, key_valid2;
  logic [3:0] key_in2, in_data2;
  logic [1:0] run_cnt2, hit_count2;

  int   checks   = 0;
  int   failures = 0;
  vec_t vq[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  match_run_detector #(.WIDTH(4), .RUN_LEN(3), .CNT_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .key_load_i(key_load), .key_in_i(key_in),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .hit_o(hit), .run_cnt_o(run_cnt), .hit_count_o(hit_count), .key_valid_o(key_valid)
  );

  match_run_detector #(.WIDTH(4), .RUN_LEN(1), .CNT_W(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .key_load_i(key_load2), .key_in_i(key_in2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_data_i(in_data2),
    .hit_o(hit2), .run_cnt_o(run_cnt2), .hit_count_o(hit_count2), .key_valid_o(key_valid2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic kl, input logic [3:0] kin, input logic v, input logic [3:0] d,
                     input logic rdy, input logic h, input int rc, input int hc, input logic kv);
    vec_t t;
    t.rst = 1'b0; t.kl = kl; t.kin = kin; t.v = v; t.d = d;
    t.rdy = rdy; t.hit = h; t.rc = 8'(rc); t.hc = 8'(hc); t.kv = kv;
    vq.push_back(t);
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    exp_t e;
    @(negedge clk);
    reset = t.rst; key_load = t.kl; key_in = t.kin; in_valid = t.v; in_data = t.d;
    #1;
    chk({tag, ".in_ready"}, int'(in_ready), int'(t.rdy));
    e.hit = t.hit; e.rc = t.rc; e.hc = t.hc; e.kv = t.kv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".hit"}, int'(hit), int'(e.hit));
    chk({tag, ".run_cnt"}, int'(run_cnt), int'(e.rc));
    chk({tag, ".hit_count"}, int'(hit_count), int'(e.hc));
    chk({tag, ".key_valid"}, int'(key_valid), int'(e.kv));
  endtask

  initial begin
    vec_t h;
    int   hc_base;
    reset = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0;
    key_load2 = 1'b0; key_in2 = '0; in_valid2 = 1'b0; in_data2 = '0;

    // No key: samples refused
    add(0, 4'h0, 1, 4'hA, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0);
    // Key A, three matches
    add(1, 4'hA, 1, 4'hA, 0, 0, 0, 0, 1);
    add(0, 4'h0, 1, 4'hA, 1, 0, 1, 0, 1);
    add(0, 4'h0, 1, 4'hA, 1, 0, 2, 0, 1);
    add(0, 4'h0, 1, 4'hA, 1, 1, 0, 1, 1);
    add(0, 4'h0, 0, 4'h0, 1, 0, 0, 1, 1);
    // Key 5: 5,5,3,5,5,5 then a match taken in HIT, idle, mismatch
    add(1, 4'h5, 0, 4'h0, 0, 0, 0, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 0, 2, 1, 1);
    add(0, 4'h0, 1, 4'h3, 1, 0, 0, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 0, 1, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 0, 2, 1, 1);
    add(0, 4'h0, 1, 4'h5, 1, 1, 0, 2, 1);
    add(0, 4'h0, 1, 4'h5, 1, 0, 1, 2, 1);
    add(0, 4'h0, 0, 4'h5, 1, 0, 1, 2, 1);
    add(0, 4'h0, 1, 4'h6, 1, 0, 0, 2, 1);
    // Key F, F,F, reload key 1 with a sample offered, then 1,1,1
    add(1, 4'hF, 0, 4'h0, 0, 0, 0, 2, 1);
    add(0, 4'h0, 1, 4'hF, 1, 0, 1, 2, 1);
    add(0, 4'h0, 1, 4'hF, 1, 0, 2, 2, 1);
    add(1, 4'h1, 1, 4'h1, 0, 0, 0, 2, 1);
    add(0, 4'h0, 1, 4'h1, 1, 0, 1, 2, 1);
    add(0, 4'h0, 1, 4'h1, 1, 0, 2, 2, 1);
    add(0, 4'h0, 1, 4'h1, 1, 1, 0, 3, 1);
    // key_load while in HIT
    add(1, 4'h7, 1, 4'h7, 0, 0, 0, 3, 1);
    // Key 7, five matches, then mismatch
    add(0, 4'h0, 1, 4'h7, 1, 0, 1, 3, 1);
    add(0, 4'h0, 1, 4'h7, 1, 0, 2, 3, 1);
    add(0, 4'h0, 1, 4'h7, 1, 1, 0, 4, 1);
`ifdef MATCH_OVERLAP_EN
    vq[$].rc = 8'd3;
    add(0, 4'h0, 1, 4'h7, 1, 1, 3, 5, 1);
    add(0, 4'h0, 1, 4'h7, 1, 1, 3, 6, 1);
    add(0, 4'h0, 1, 4'h0, 1, 0, 0, 6, 1);
`else
    add(0, 4'h0, 1, 4'h7, 1, 0, 1, 4, 1);
    add(0, 4'h0, 1, 4'h7, 1, 0, 2, 4, 1);
    add(0, 4'h0, 1, 4'h0, 1, 0, 0, 4, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", int'(in_ready), 0);
    chk("reset.hit", int'(hit), 0);
    chk("reset.run_cnt", int'(run_cnt), 0);
    chk("reset.hit_count", int'(hit_count), 0);
    chk("reset.key_valid", int'(key_valid), 0);

    foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

    // Reset asserted together with key_load during a HIT cycle
    hc_base = int'(vq[$].hc);
    h = vq[$];
    h.kl = 0; h.v = 1; h.d = 4'h7; h.rdy = 1;
    h.hit = 0; h.rc = 1; h.hc = 8'(hc_base); run_vec(h, "rstseq.a");
    h.rc = 2; run_vec(h, "rstseq.b");
    h.hit = 1; h.rc = 0; h.hc = 8'(hc_base + 1);
`ifdef MATCH_OVERLAP_EN
    h.rc = 3;
`endif
    run_vec(h, "rstseq.c");
    h.rst = 1; h.kl = 1; h.kin = 4'h3; h.rdy = 0;
    h.hit = 0; h.rc = 0; h.hc = 0; h.kv = 0; run_vec(h, "rstseq.d");
    h.rst = 0; h.kl = 0; h.d = 4'h3; run_vec(h, "rstseq.e");

    // RUN_LEN=1, CNT_W=2: every zero sample hits, tally sticks at 3
    @(negedge clk);
    key_load2 = 1'b1; key_in2 = 4'h0; in_valid2 = 1'b1; in_data2 = 4'h0;
    @(posedge clk); #1;
    chk("rl1.load_hit", int'(hit2), 0);
    chk("rl1.key_valid", int'(key_valid2), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_load2 = 1'b0;
      #1;
      chk($sformatf("rl1.s%0d.in_ready", i), int'(in_ready2), 1);
      @(posedge clk); #1;
      chk($sformatf("rl1.s%0d.hit", i), int'(hit2), 1);
      chk($sformatf("rl1.s%0d.hit_count", i), int'(hit_count2), (i < 3) ? i + 1 : 3);
`ifdef MATCH_OVERLAP_EN
      chk($sformatf("rl1.s%0d.run_cnt", i), int'(run_cnt2), 1);
`else
      chk($sformatf("rl1.s%0d.run_cnt", i), int'(run_cnt2), 0);
`endif
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("rl1.idle.hit", int'(hit2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
